multiplier_ctrl: RTL and testbench
==================================

MULTIPLIER_CTRL -- requirements
Module: multiplier_ctrl

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits and product width at 64 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op_start  input  1  start request; sampled only in state INIT.
REQ-005 op_clear  input  1  abort/acknowledge; returns the block to INIT from any state.
REQ-006 multiplicand  input  32  signed two's-complement operand M.
REQ-007 multiplier  input  32  signed two's-complement operand Q.
REQ-008 op_busy  output  1  high while state is EXEC.
REQ-009 op_done  output  1  high while state is DONE.
REQ-010 result  output  64  signed product; valid while op_done=1.

Function
REQ-011 The block SHALL implement a radix-2 Booth sequential multiplier: a 2-bit state register, a 6-bit iteration counter, a 33-bit signed accumulator U, a 32-bit shift register Q and a 1-bit q_prev.
REQ-012 State encoding SHALL be INIT=2'b00, EXEC=2'b01, DONE=2'b10; 2'b11 is illegal and SHALL go to INIT on the next edge with all registers cleared.
REQ-013 In INIT, an edge with op_start=1 and op_clear=0 SHALL capture multiplicand into M, multiplier into Q, clear U, q_prev and the counter, and go to EXEC.
REQ-014 Operands SHALL be captured only on the start edge; later changes on the inputs SHALL have no effect on the operation in progress.
REQ-015 Each EXEC edge SHALL perform one Booth step on {Q[0],q_prev}: 01 -> U=U+sext(M); 10 -> U=U-sext(M); 00/11 -> U unchanged. It SHALL then arithmetic-shift {U,Q,q_prev} right by 1 and increment the counter.
REQ-016 The EXEC edge with counter==31 SHALL perform the 32nd step and go to DONE; the counter then wraps to 0.
REQ-017 Latency: op_done SHALL rise after exactly 33 rising edges, counting the start edge as edge 1.
REQ-018 result SHALL equal {U[31:0],Q} in DONE and SHALL be 64'h0 in INIT and EXEC.
REQ-019 The product SHALL be exact for all 2^64 operand pairs, including 32'h80000000 x 32'h80000000; the 33-bit U prevents overflow.
REQ-020 DONE SHALL hold result and op_done stable until an edge with op_clear=1, which SHALL go to INIT.
REQ-021 op_start in EXEC or DONE SHALL be ignored; it SHALL neither restart nor queue an operation.
REQ-022 op_clear=1 in EXEC SHALL abort on that edge: state INIT, counter 0, U/Q/q_prev 0, op_busy 0.
REQ-023 op_start and op_clear both high in INIT SHALL leave the block in INIT; clear wins.
REQ-024 A new operation SHALL start no earlier than the edge after the return to INIT; the minimum issue interval is 35 edges.
REQ-025 op_busy and op_done SHALL be decoded from state only (Moore) and SHALL never be high together.

Reset
REQ-026 When reset=1, independent of clk, the block SHALL immediately set state=INIT, counter=0, M=0, U=0, Q=0 and q_prev=0.
REQ-027 During reset: op_busy=0, op_done=0, result=64'h0.
REQ-028 A reset asserted mid-EXEC SHALL discard the operation; after reset deasserts, the block SHALL accept a new op_start on the first clock edge.
REQ-029 Reset deassertion SHALL be synchronized to clk; the first edge after deassertion SHALL see reset=0.

Verification
REQ-030 Start with M=5, Q=3 -> op_busy high for 32 cycles; op_done rises on edge 33; result=64'h000000000000000F.
REQ-031 M=32'hFFFFFFFF, Q=32'hFFFFFFFF -> result=64'h0000000000000001. M=32'h80000000, Q=32'h80000000 -> result=64'h4000000000000000.
REQ-032 M=32'h7FFFFFFF, Q=32'h80000000 -> result=64'hC000000080000000. M=-7, Q=6 -> result=64'hFFFFFFFFFFFFFFD6.
REQ-033 Start 5x3, then pulse op_start and change operands at EXEC cycle 5 -> result still 64'h0F on edge 33.
REQ-034 Start, then op_clear at EXEC cycle 10 -> INIT on that edge with op_busy=0 and result=0. Start 2x2 on the following edge -> result=64'h4.
REQ-035 Assert reset asynchronously mid-EXEC -> outputs zero without a clock edge. In DONE, op_start and op_clear together -> INIT, no restart.

Source files
------------

// File: rtl/multiplier_ctrl.sv
`default_nettype none
// ---- multiplier_ctrl : radix-2 Booth sequential 32x32 signed multiplier (33-edge latency) ----
// ---- rev 1.0 ----
module multiplier_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        op_busy,
  output logic        op_done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    INIT    = 2'b00,
    EXEC    = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] m_q, m_d;
  logic [32:0] u_q, u_d;
  logic [31:0] q_q, q_d;
  logic        qp_q, qp_d;

  logic [32:0] m_ext;
  logic [32:0] sum;

  // One Booth add/subtract on the current {Q[0], q_prev} pair
  always_comb begin
    m_ext = {m_q[31], m_q};
    sum   = u_q;
    case ({q_q[0], qp_q})
      2'b01:   sum = u_q + m_ext;
      2'b10:   sum = u_q - m_ext;
      default: sum = u_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    u_d     = u_q;
    q_d     = q_q;
    qp_d    = qp_q;
    case (state_q)
      INIT: begin
        if (op_start && !op_clear) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          u_d     = 33'd0;
          qp_d    = 1'b0;
          cnt_d   = 6'd0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_clear) begin
          cnt_d   = 6'd0;
          u_d     = 33'd0;
          q_d     = 32'd0;
          qp_d    = 1'b0;
          state_d = INIT;
        end else begin
          // Arithmetic right shift of {U, Q, q_prev}
          u_d  = {sum[32], sum[32:1]};
          q_d  = {sum[0], q_q[31:1]};
          qp_d = q_q[0];
          if (cnt_q == 6'd31) begin
            cnt_d   = 6'd0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      DONE: begin
        if (op_clear) begin
          cnt_d   = 6'd0;
          u_d     = 33'd0;
          q_d     = 32'd0;
          qp_d    = 1'b0;
          state_d = INIT;
        end
      end
      default: begin
        cnt_d   = 6'd0;
        m_d     = 32'd0;
        u_d     = 33'd0;
        q_d     = 32'd0;
        qp_d    = 1'b0;
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= 6'd0;
      m_q     <= 32'd0;
      u_q     <= 33'd0;
      q_q     <= 32'd0;
      qp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      u_q     <= u_d;
      q_q     <= q_d;
      qp_q    <= qp_d;
    end
  end

  assign op_busy = (state_q == EXEC);
  assign op_done = (state_q == DONE);
  assign result  = op_done ? {u_q[31:0], q_q} : 64'h0;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_ctrl.sv
`default_nettype none
// ---- tb_multiplier_ctrl : directed self-checking bench for multiplier_ctrl ----
// ---- rev 1.0 ----
module tb_multiplier_ctrl;

  logic        clk;
  logic        reset;
  logic        op_start;
  logic        op_clear;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        op_busy;
  logic        op_done;
  logic [63:0] result;

  int errors;
  int checks;

  multiplier_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_busy      (op_busy),
    .op_done      (op_done),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_start = 1'b0; op_clear = 1'b0;
    multiplicand = 32'd0; multiplier = 32'd0;
    tick(); tick();
    checks++;
    if ({op_busy, op_done, result} !== 66'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b result=%h, required 0/0/0", op_busy, op_done, result);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({op_busy, op_done, result} !== 66'd0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%0b done=%0b result=%h, required 0/0/0", op_busy, op_done, result);
    end
  endtask

  // Full operation: start, count edges to done, check product, then clear
  task automatic run_mult(input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp, input string name);
    int edges;
    int busy_cycles;
    multiplicand = m; multiplier = q; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    edges = 1;
    busy_cycles = op_busy ? 1 : 0;
    checks++;
    if (op_busy !== 1'b1 || result !== 64'h0) begin
      errors++;
      $display("FAIL %s_start: busy=%0b result=%h, required busy=1 result=0", name, op_busy, result);
    end
    while (op_done !== 1'b1 && edges < 40) begin
      tick();
      edges++;
      if (op_busy === 1'b1) busy_cycles++;
    end
    checks++;
    if (edges != 33 || busy_cycles != 32) begin
      errors++;
      $display("FAIL %s_latency: done on edge %0d busy %0d cycles, required edge 33 busy 32", name, edges, busy_cycles);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s_result: got %h, required %h", name, result, exp);
    end
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    checks++;
    if ({op_busy, op_done, result} !== 66'd0) begin
      errors++;
      $display("FAIL %s_clear: busy=%0b done=%0b result=%h, required 0/0/0", name, op_busy, op_done, result);
    end
  endtask

  task automatic test_products();
    run_mult(32'd5, 32'd3, 64'h000000000000000F, "m5x3");
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, "neg1sq");
    run_mult(32'h80000000, 32'h80000000, 64'h4000000000000000, "minsq");
    run_mult(32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, "maxmin");
    run_mult(32'hFFFFFFF9, 32'd6, 64'hFFFFFFFFFFFFFFD6, "m7x6");
  endtask

  task automatic test_ignore_start();
    int edges;
    multiplicand = 32'd5; multiplier = 32'd3; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    edges = 1;
    repeat (5) begin tick(); edges++; end
    multiplicand = 32'd9; multiplier = 32'd11; op_start = 1'b1;
    tick(); edges++;
    op_start = 1'b0;
    while (op_done !== 1'b1 && edges < 40) begin tick(); edges++; end
    checks++;
    if (edges != 33 || result !== 64'hF) begin
      errors++;
      $display("FAIL ignore_start: done edge %0d result %h, required edge 33 result %h", edges, result, 64'hF);
    end
    op_start = 1'b1;
    repeat (3) tick();
    op_start = 1'b0;
    checks++;
    if (op_done !== 1'b1 || op_busy !== 1'b0 || result !== 64'hF) begin
      errors++;
      $display("FAIL done_hold: done=%0b busy=%0b result=%h, required 1/0/%h", op_done, op_busy, result, 64'hF);
    end
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
  endtask

  task automatic test_abort();
    multiplicand = 32'd5; multiplier = 32'd3; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (9) tick();
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    checks++;
    if ({op_busy, op_done, result} !== 66'd0) begin
      errors++;
      $display("FAIL abort: busy=%0b done=%0b result=%h, required 0/0/0", op_busy, op_done, result);
    end
    run_mult(32'd2, 32'd2, 64'h4, "after_abort");
  endtask

  task automatic test_start_clear_init();
    multiplicand = 32'd4; multiplier = 32'd4;
    op_start = 1'b1; op_clear = 1'b1;
    tick();
    op_start = 1'b0; op_clear = 1'b0;
    tick();
    checks++;
    if (op_busy !== 1'b0 || op_done !== 1'b0) begin
      errors++;
      $display("FAIL init_clear_wins: busy=%0b done=%0b, required 0/0", op_busy, op_done);
    end
  endtask

  task automatic test_async_reset();
    multiplicand = 32'd5; multiplier = 32'd3; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (4) tick();
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({op_busy, op_done, result} !== 66'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%0b done=%0b result=%h, required 0/0/0", op_busy, op_done, result);
    end
    tick();
    reset = 1'b0;
    run_mult(32'd6, 32'd7, 64'd42, "after_reset");
  endtask

  task automatic test_done_start_clear();
    multiplicand = 32'd3; multiplier = 32'd3; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (32) tick();
    checks++;
    if (op_done !== 1'b1 || result !== 64'd9) begin
      errors++;
      $display("FAIL done_reached: done=%0b result=%h, required 1/%h", op_done, result, 64'd9);
    end
    op_start = 1'b1; op_clear = 1'b1;
    tick();
    op_start = 1'b0; op_clear = 1'b0;
    tick();
    checks++;
    if ({op_busy, op_done, result} !== 66'd0) begin
      errors++;
      $display("FAIL done_start_clear: busy=%0b done=%0b result=%h, required 0/0/0", op_busy, op_done, result);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_products();
    test_ignore_start();
    test_abort();
    test_start_clear_init();
    test_async_reset();
    test_done_start_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
